// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge pipeline back end.
package sobel_pkg;

  localparam int PIX_W       = 8;
  localparam int FRAME_W_DEF = 62;
  localparam int FRAME_H_DEF = 62;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE,
    ST_READOUT
  } cap_state_t;

endpackage

// File: rtl/edge_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module edge_frame_ram
  import sobel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/edge_frame_capture.sv
// Captures one Sobel edge frame into RAM, counts strong edges and replays
// the stored frame over a ready/valid port.
module edge_frame_capture
  import sobel_pkg::*;
#(
  parameter int               FRAME_W = FRAME_W_DEF,
  parameter int               FRAME_H = FRAME_H_DEF,
  parameter logic [PIX_W-1:0] THRESH  = 8'd128,
  localparam int              N       = FRAME_W * FRAME_H,
  localparam int              AW      = $clog2(N),
  localparam int              CW      = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [PIX_W-1:0] edge_in,
  input  logic             edge_valid,
  input  logic             rd_start,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_ready,
  output logic             overflow,
  output logic [CW-1:0]    edge_count
);

  cap_state_t state, state_next;

  logic [AW-1:0]    wr_addr;
  logic [CW-1:0]    rd_cnt;
  logic             cap_wr, last_wr, start_cap, start_rd;
  logic             issue, pop, inflight, inflight_last;
  logic [2:0]       occupancy;
  logic [1:0]       fifo_cnt;
  logic [PIX_W-1:0] ram_q, q0_data, q1_data;
  logic             q0_last, q1_last;

  assign cap_wr    = (state == ST_CAPTURE) && edge_valid;
  assign last_wr   = cap_wr && (wr_addr == AW'(N - 1));
  assign start_cap = arm && ((state == ST_IDLE) || (state == ST_DONE));
  assign start_rd  = rd_start && !arm && (state == ST_DONE);

  assign rd_valid = (fifo_cnt != 2'd0);
  assign rd_data  = q0_data;
  assign rd_last  = q0_last && rd_valid;
  assign pop      = rd_valid && rd_ready;
  assign busy     = (state == ST_CAPTURE) || (state == ST_READOUT);

  // A read may only be issued if its data is guaranteed a skid slot when it lands.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ST_READOUT) && (rd_cnt < CW'(N)) && (occupancy <= 3'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (arm) state_next = ST_CAPTURE;
      ST_CAPTURE: if (last_wr) state_next = ST_DONE;
      ST_DONE: begin
        if (arm)           state_next = ST_CAPTURE;
        else if (rd_start) state_next = ST_READOUT;
      end
      ST_READOUT: if (pop && rd_last) state_next = ST_DONE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr     <= '0;
      edge_count  <= '0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      frame_done <= last_wr;
      if (start_cap) begin
        wr_addr     <= '0;
        edge_count  <= '0;
        overflow    <= 1'b0;
        frame_ready <= 1'b0;
      end else begin
        if (cap_wr) begin
          wr_addr <= wr_addr + AW'(1);
          if (edge_in >= THRESH) edge_count <= edge_count + CW'(1);
        end
        if (last_wr) frame_ready <= 1'b1;
        if (edge_valid && ((state == ST_DONE) || (state == ST_READOUT))) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (rd_cnt == CW'(N - 1));
      if (start_rd)   rd_cnt <= '0;
      else if (issue) rd_cnt <= rd_cnt + CW'(1);
    end
  end

  // Two-entry skid queue; q0 is the presented beat, q1 holds overflow under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      q0_data  <= '0;
      q1_data  <= '0;
      q0_last  <= 1'b0;
      q1_last  <= 1'b0;
    end else begin
      unique case ({inflight, pop})
        2'b11: begin
          if (fifo_cnt == 2'd2) begin
            q0_data <= q1_data;
            q0_last <= q1_last;
            q1_data <= ram_q;
            q1_last <= inflight_last;
          end else begin
            q0_data <= ram_q;
            q0_last <= inflight_last;
          end
        end
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            q0_data <= ram_q;
            q0_last <= inflight_last;
          end else begin
            q1_data <= ram_q;
            q1_last <= inflight_last;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          q0_data  <= q1_data;
          q0_last  <= q1_last;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  edge_frame_ram #(
    .DEPTH (N),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (cap_wr),
    .wr_addr (wr_addr),
    .wr_data (edge_in),
    .rd_en   (issue),
    .rd_addr (rd_cnt[AW-1:0]),
    .rd_data (ram_q)
  );

endmodule
